vga_text_console_ctrl: RTL and testbench
========================================

// Module: vga_text_console_ctrl
// PURPOSE
//  Sequencer owning port A of the VGA text framebuffer (dual_port_ram_sync, port B stays with the scan-out).
//  Accepts a character stream from the AHB VGA slave via valid/ready and writes glyph codes at a hardware cursor.
//  Handles CR/LF/backspace, line wrap, full-screen clear and scroll-up (row copy through port A, last row blanked).
// PARAMETERS
//  COLS        32    characters per row
//  ROWS        30    rows per screen
//  ADDR_WIDTH  10    RAM address width; COLS*ROWS <= 2**ADDR_WIDTH
//  DATA_WIDTH  8     character code width
//  BLANK       8'h20 fill code for clear/scroll
// PORTS
//  clk         in   1           system clock (single clock domain)
//  reset       in   1           synchronous, active-high reset
//  char_valid  in   1           character offered
//  char_data   in   DATA_WIDTH  character code
//  char_ready  out  1           character accepted when char_valid&&char_ready at posedge clk
//  clear_req   in   1           request full-screen clear (sampled in IDLE only)
//  busy        out  1           1 in any state other than IDLE
//  ram_we      out  1           to RAM we
//  ram_addr    out  ADDR_WIDTH  to RAM addr_a; address = row*COLS + col
//  ram_din     out  DATA_WIDTH  to RAM din_a
//  ram_dout    in   DATA_WIDTH  from RAM dout_a (valid 1 cycle after ram_addr presented)
//  cursor_row  out  $clog2(ROWS) current row
//  cursor_col  out  $clog2(COLS) current column
// BEHAVIOUR
//  - Interface: one clock, clk; reset synchronous active-high, named reset.
//  - All outputs registered except char_ready = (state==IDLE) && !clear_req.
//  - Reset: state IDLE, ram_we=0, ram_addr=0, ram_din=0, cursor 0/0, busy=0. Reset mid-sequence aborts at once;
//    RAM contents left partially updated (not restored); no further write after the reset edge.
//  - States: IDLE, PUT, SCRL_RD, SCRL_WR, CLR.
//  - IDLE, clear_req=1: -> CLR, addr=0, cursor->0/0. clear_req wins over simultaneous char_valid (char not taken).
//  - IDLE, handshake, printable (0x20..0x7E): -> PUT; next cycle ram_we=1, addr=cursor, din=char_data.
//    Then col+1; col==COLS-1 -> col=0, row advance.
//  - 0x0A LF: col=0, row advance. 0x0D CR: col=0. 0x08 BS: col-1 if col>0, no erase. Other codes: consumed, no write.
//    Non-printables take 1 cycle, stay IDLE.
//  - Row advance: row<ROWS-1 -> row+1. row==ROWS-1 -> scroll (see CONFIGURATION), row stays ROWS-1.
//  - Scroll, 2 cycles/char, src addr COLS..COLS*ROWS-1 ascending:
//    SCRL_RD: ram_we=0, addr=src. SCRL_WR: ram_we=1, addr=src-COLS, din=ram_dout.
//    Then CLR over last row (addr COLS*(ROWS-1)..COLS*ROWS-1), then IDLE.
//  - CLR: ram_we=1, din=BLANK, addr increments 1/cycle to end of range, then IDLE (ram_we drops).
//  - Timing (32x30): scroll = 2*29*32+32 = 1888 cycles; full clear = 960 cycles; PUT = 1 cycle.
//  - A PUT that triggers a scroll: char written first, scroll follows directly.
//  - busy=1 and char_ready=0 throughout PUT/SCRL_*/CLR; inputs ignored there.
//  - Cursor outputs update on the handshake cycle edge (reflect post-character position).
// CONFIGURATION
//  CONSOLE_AUTOSCROLL_EN defined: row advance at ROWS-1 runs scroll sequence as above.
//  Not defined: row advance at ROWS-1 wraps row to 0, no RAM traffic; SCRL_RD/SCRL_WR states not built.
// TESTING
//  1 reset, send 'A'(0x41) -> 1 cycle later ram_we=1, addr=0, din=0x41; cursor 0/1; busy high 1 cycle.
//  2 32 printables from 0/0 -> writes at addr 0..31, cursor 1/0; then 0x0D, 0x0A, 0x08 at col 0 -> no writes, cursor 2/0.
//  3 clear_req with char_valid same cycle -> char_ready=0; 960 writes of 0x20 addr 0..959; cursor 0/0; busy 960 cycles.
//  4 (_EN) preload row r with r; LF at row 29 -> 1888 busy cycles, RAM[k*32]=k+1 for k<29, row 29 all 0x20, cursor 29/0.
//  5 (no _EN) LF at row 29 -> cursor 0/0, no ram_we, busy stays 0.
//  6 reset asserted mid-scroll -> next edge ram_we=0, IDLE, cursor 0/0, char_ready=1.

Source files
------------

// File: rtl/vga_text_console_ctrl_if.sv
// Character-stream handshake and framebuffer port-A bus for vga_text_console_ctrl.
// master = character source plus RAM side; slave = the console sequencer.
interface vga_text_console_ctrl_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
);
  logic                  char_valid;
  logic [DATA_WIDTH-1:0] char_data;
  logic                  char_ready;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;

  modport master (
    output char_valid, char_data, ram_dout,
    input  char_ready, ram_we, ram_addr, ram_din
  );

  modport slave (
    input  char_valid, char_data, ram_dout,
    output char_ready, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/vga_text_console_ctrl.sv
// Text console sequencer owning framebuffer port A: cursor, CR/LF/BS, clear and scroll-up.
// Define CONSOLE_AUTOSCROLL_EN to scroll at the bottom row; otherwise the cursor wraps to row 0.
module vga_text_console_ctrl #(
  parameter int                    COLS       = 32,
  parameter int                    ROWS       = 30,
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] BLANK      = 8'h20,
  localparam int                   ROW_W      = $clog2(ROWS),
  localparam int                   COL_W      = $clog2(COLS)
) (
  input  logic                 clk,
  input  logic                 reset,
  vga_text_console_ctrl_if.slave bus,
  input  logic                 clear_req,
  output logic                 busy,
  output logic [ROW_W-1:0]     cursor_row,
  output logic [COL_W-1:0]     cursor_col
);

`ifdef CONSOLE_AUTOSCROLL_EN
  typedef enum logic [2:0] {IDLE, PUT, SCRL_RD, SCRL_WR, CLR} state_t;
`else
  typedef enum logic [1:0] {IDLE, PUT, CLR} state_t;
`endif

  localparam logic [ADDR_WIDTH-1:0] A_COLS     = ADDR_WIDTH'(COLS);
  localparam logic [ADDR_WIDTH-1:0] A_LAST     = ADDR_WIDTH'(COLS * ROWS - 1);
  localparam logic [COL_W-1:0]      COL_LAST   = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]      ROW_LAST   = ROW_W'(ROWS - 1);
  localparam logic [DATA_WIDTH-1:0] CH_LF      = DATA_WIDTH'(8'h0A);
  localparam logic [DATA_WIDTH-1:0] CH_CR      = DATA_WIDTH'(8'h0D);
  localparam logic [DATA_WIDTH-1:0] CH_BS      = DATA_WIDTH'(8'h08);
  localparam logic [DATA_WIDTH-1:0] CH_LO      = DATA_WIDTH'(8'h20);
  localparam logic [DATA_WIDTH-1:0] CH_HI      = DATA_WIDTH'(8'h7E);

  state_t                  state, state_n;
  logic                    we_q, we_n;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_n;
  logic [DATA_WIDTH-1:0]   din_q, din_n;
  logic [ROW_W-1:0]        row_q, row_n;
  logic [COL_W-1:0]        col_q, col_n;
  logic                    busy_q;
  logic                    adv;
  logic                    is_print;
  logic [ADDR_WIDTH-1:0]   cur_addr;

  assign is_print = (bus.char_data >= CH_LO) && (bus.char_data <= CH_HI);
  assign cur_addr = ADDR_WIDTH'(row_q) * A_COLS + ADDR_WIDTH'(col_q);

  assign bus.char_ready = (state == IDLE) && !clear_req;
  assign bus.ram_we     = we_q;
  assign bus.ram_addr   = addr_q;
  assign busy           = busy_q;
  assign cursor_row     = row_q;
  assign cursor_col     = col_q;

`ifdef CONSOLE_AUTOSCROLL_EN
  localparam logic [ADDR_WIDTH-1:0] A_LASTROW  = ADDR_WIDTH'(COLS * (ROWS - 1));
  localparam logic [ADDR_WIDTH-1:0] A_SCRL_END = ADDR_WIDTH'(COLS * (ROWS - 1) - 1);

  // A printable that lands past the bottom-right cell writes first, then scrolls.
  logic pend_q, pend_n;

  // Scroll data is forwarded from the RAM's registered read port so a row copy costs 2 cycles/char.
  assign bus.ram_din = (state == SCRL_WR) ? bus.ram_dout : din_q;
`else
  logic unused_dout;
  assign unused_dout = ^bus.ram_dout;
  assign bus.ram_din = din_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      we_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
      row_q  <= '0;
      col_q  <= '0;
      busy_q <= 1'b0;
`ifdef CONSOLE_AUTOSCROLL_EN
      pend_q <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      we_q   <= we_n;
      addr_q <= addr_n;
      din_q  <= din_n;
      row_q  <= row_n;
      col_q  <= col_n;
      busy_q <= (state_n != IDLE);
`ifdef CONSOLE_AUTOSCROLL_EN
      pend_q <= pend_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    we_n    = 1'b0;
    addr_n  = addr_q;
    din_n   = din_q;
    row_n   = row_q;
    col_n   = col_q;
    adv     = 1'b0;
`ifdef CONSOLE_AUTOSCROLL_EN
    pend_n  = pend_q;
`endif
    case (state)
      IDLE: begin
        if (clear_req) begin
          state_n = CLR;
          we_n    = 1'b1;
          addr_n  = '0;
          din_n   = BLANK;
          row_n   = '0;
          col_n   = '0;
        end else if (bus.char_valid) begin
          if (is_print) begin
            state_n = PUT;
            we_n    = 1'b1;
            addr_n  = cur_addr;
            din_n   = bus.char_data;
            if (col_q == COL_LAST) begin
              col_n = '0;
              adv   = 1'b1;
            end else begin
              col_n = col_q + 1'b1;
            end
          end else if (bus.char_data == CH_LF) begin
            col_n = '0;
            adv   = 1'b1;
          end else if (bus.char_data == CH_CR) begin
            col_n = '0;
          end else if ((bus.char_data == CH_BS) && (col_q != '0)) begin
            col_n = col_q - 1'b1;
          end
          if (adv) begin
            if (row_q != ROW_LAST) begin
              row_n = row_q + 1'b1;
            end else begin
`ifdef CONSOLE_AUTOSCROLL_EN
              if (is_print) begin
                pend_n = 1'b1;
              end else begin
                state_n = SCRL_RD;
                addr_n  = A_COLS;
              end
`else
              row_n = '0;
`endif
            end
          end
        end
      end
      PUT: begin
`ifdef CONSOLE_AUTOSCROLL_EN
        if (pend_q) begin
          pend_n  = 1'b0;
          state_n = SCRL_RD;
          addr_n  = A_COLS;
        end else begin
          state_n = IDLE;
        end
`else
        state_n = IDLE;
`endif
      end
`ifdef CONSOLE_AUTOSCROLL_EN
      SCRL_RD: begin
        state_n = SCRL_WR;
        we_n    = 1'b1;
        addr_n  = addr_q - A_COLS;
      end
      SCRL_WR: begin
        if (addr_q == A_SCRL_END) begin
          state_n = CLR;
          we_n    = 1'b1;
          addr_n  = A_LASTROW;
          din_n   = BLANK;
        end else begin
          state_n = SCRL_RD;
          addr_n  = addr_q + A_COLS + 1'b1;
        end
      end
`endif
      CLR: begin
        if (addr_q == A_LAST) begin
          state_n = IDLE;
        end else begin
          we_n   = 1'b1;
          addr_n = addr_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vga_text_console_ctrl.sv
// Scoreboard bench for vga_text_console_ctrl: expected RAM writes are queued by the stimulus,
// a negedge monitor pops and compares every ram_we cycle. Follows CONSOLE_AUTOSCROLL_EN if defined.
module tb_vga_text_console_ctrl;
  typedef struct {
    logic [9:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear_req = 1'b0;
  logic       busy;
  logic [4:0] cursor_row;
  logic [4:0] cursor_col;
  logic [7:0] mem [0:1023];
  wr_t        q [$];
  int         n_cmp = 0;
  int         n_bad = 0;

  vga_text_console_ctrl_if #(.ADDR_WIDTH(10), .DATA_WIDTH(8)) bus ();

  vga_text_console_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .clear_req  (clear_req),
    .busy       (busy),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col)
  );

  always #5 clk = ~clk;

  // Synchronous read-first RAM model standing in for port A of the framebuffer.
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end

  always @(negedge clk) begin
    if (!reset && bus.ram_we) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: addr %0d data %0h, no write expected", bus.ram_addr, bus.ram_din);
      end else begin
        wr_t e;
        e = q.pop_front();
        if (bus.ram_addr !== e.a || bus.ram_din !== e.d) begin
          n_bad++;
          $display("FAIL ram_write: got addr %0d data %0h, expected addr %0d data %0h",
                   bus.ram_addr, bus.ram_din, e.a, e.d);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input int a, input int d);
    wr_t e;
    e.a = 10'(a);
    e.d = 8'(d);
    q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic send_char(input logic [7:0] c);
    int w;
    w = 0;
    bus.char_valid = 1'b1;
    bus.char_data  = c;
    while (!bus.char_ready && w < 4000) begin
      tick();
      w++;
    end
    if (!bus.char_ready) chk("char_ready_timeout", 32'(bus.char_ready), 32'd1);
    tick();
    bus.char_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output int cnt);
    cnt = 0;
    while (busy && cnt < limit) begin
      cnt++;
      tick();
    end
    if (busy) chk("busy_timeout", 32'(busy), 32'd0);
  endtask

  task automatic preload_rows();
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 32; c++)
        mem[r * 32 + c] <= 8'(r);
    #1;
  endtask

  task automatic push_scroll();
    for (int s = 32; s < 960; s++) push_wr(s - 32, s / 32);
    for (int a = 928; a < 960; a++) push_wr(a, 8'h20);
  endtask

  initial begin
    int cnt;
    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;
    for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    repeat (3) tick();
    reset = 1'b0;

    // 1: reset state, then one printable
    chk("rst_ram_we", 32'(bus.ram_we), 0);
    chk("rst_ram_addr", 32'(bus.ram_addr), 0);
    chk("rst_ram_din", 32'(bus.ram_din), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_row", 32'(cursor_row), 0);
    chk("rst_col", 32'(cursor_col), 0);
    chk("rst_char_ready", 32'(bus.char_ready), 1);
    push_wr(0, 8'h41);
    send_char(8'h41);
    chk("put_we", 32'(bus.ram_we), 1);
    chk("put_addr", 32'(bus.ram_addr), 0);
    chk("put_din", 32'(bus.ram_din), 8'h41);
    chk("put_row", 32'(cursor_row), 0);
    chk("put_col", 32'(cursor_col), 1);
    wait_idle(10, cnt);
    chk("put_busy_cycles", 32'(cnt), 1);

    // 2: full row with wrap, then control codes
    do_reset();
    for (int i = 0; i < 32; i++) begin
      push_wr(i, 8'h20 + 3 * i);
      send_char(8'(8'h20 + 3 * i));
      wait_idle(10, cnt);
    end
    chk("row_wrap_row", 32'(cursor_row), 1);
    chk("row_wrap_col", 32'(cursor_col), 0);
    send_char(8'h0D);
    chk("cr_busy", 32'(busy), 0);
    send_char(8'h0A);
    send_char(8'h08);
    chk("ctrl_row", 32'(cursor_row), 2);
    chk("ctrl_col", 32'(cursor_col), 0);
    push_wr(64, 8'h78);
    send_char(8'h78);
    wait_idle(10, cnt);
    chk("x_col", 32'(cursor_col), 1);
    send_char(8'h7F);
    chk("del_col", 32'(cursor_col), 1);
    send_char(8'h08);
    chk("bs_col", 32'(cursor_col), 0);
    chk("bs_row", 32'(cursor_row), 2);

    // 3: clear wins over a simultaneous character
    for (int a = 0; a < 960; a++) push_wr(a, 8'h20);
    clear_req = 1'b1;
    bus.char_valid = 1'b1;
    bus.char_data  = 8'h5A;
    #1;
    chk("clr_char_ready", 32'(bus.char_ready), 0);
    tick();
    clear_req = 1'b0;
    bus.char_valid = 1'b0;
    chk("clr_row", 32'(cursor_row), 0);
    chk("clr_col", 32'(cursor_col), 0);
    wait_idle(2000, cnt);
    chk("clr_busy_cycles", 32'(cnt), 960);
    chk("clr_queue_drained", 32'(q.size()), 0);

    for (int i = 0; i < 29; i++) send_char(8'h0A);
    chk("lf29_row", 32'(cursor_row), 29);
    chk("lf29_col", 32'(cursor_col), 0);
`ifdef CONSOLE_AUTOSCROLL_EN
    // 4: scroll at the bottom row
    preload_rows();
    push_scroll();
    send_char(8'h0A);
    wait_idle(4000, cnt);
    chk("scroll_busy_cycles", 32'(cnt), 1888);
    for (int k = 0; k < 29; k++) chk($sformatf("scroll_row%0d", k), 32'(mem[k * 32]), 32'(k + 1));
    for (int c = 0; c < 32; c++) chk($sformatf("scroll_blank%0d", c), 32'(mem[928 + c]), 8'h20);
    chk("scroll_row", 32'(cursor_row), 29);
    chk("scroll_col", 32'(cursor_col), 0);
    chk("scroll_queue_drained", 32'(q.size()), 0);

    // 6: reset mid-scroll
    preload_rows();
    push_scroll();
    send_char(8'h0A);
`else
    // 5: wrap to the top without RAM traffic
    send_char(8'h0A);
    chk("wrap_busy", 32'(busy), 0);
    chk("wrap_row", 32'(cursor_row), 0);
    chk("wrap_col", 32'(cursor_col), 0);
    tick();
    chk("wrap_busy_after", 32'(busy), 0);

    // 6: reset mid-clear
    for (int a = 0; a < 960; a++) push_wr(a, 8'h20);
    send_char(8'h0A);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
`endif
    repeat (100) tick();
    chk("mid_busy", 32'(busy), 1);
    reset = 1'b1;
    tick();
    chk("abort_we", 32'(bus.ram_we), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_row", 32'(cursor_row), 0);
    chk("abort_col", 32'(cursor_col), 0);
    chk("abort_char_ready", 32'(bus.char_ready), 1);
    reset = 1'b0;
    q.delete();
    repeat (10) tick();
    push_wr(0, 8'h5A);
    send_char(8'h5A);
    wait_idle(10, cnt);
    chk("post_abort_col", 32'(cursor_col), 1);
    repeat (3) tick();
    chk("final_queue_drained", 32'(q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
